// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel-rate divider, x/y scan counters,
// registered sync/blank decode and a per-frame strobe.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       p_tick,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_M1 = 4'(CLK_DIV - 1);
  localparam logic [9:0] HT_M1  = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT_M1  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HD     = 10'(H_DISPLAY);
  localparam logic [9:0] VD     = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI  = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI  = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [3:0] div;
  logic [3:0] div_nxt;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       x_wrap;
  logic       y_wrap;
  logic       wrap_all;

  always_comb begin
    p_tick   = (div == DIV_M1) && !reset;
    x_wrap   = (x == HT_M1);
    y_wrap   = (y == VT_M1);
    wrap_all = p_tick && x_wrap && y_wrap;
    div_nxt  = (div == DIV_M1) ? 4'd0 : div + 4'd1;
    x_nxt    = x;
    y_nxt    = y;
    if (p_tick) begin
      x_nxt = x_wrap ? 10'd0 : x + 10'd1;
      if (x_wrap)
        y_nxt = y_wrap ? 10'd0 : y + 10'd1;
    end
  end

  // Decode from next-state counts so the flags line up with x/y.
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      x           <= '0;
      y           <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      hsync       <= !(x_nxt >= HS_LO && x_nxt < HS_HI);
      vsync       <= !(y_nxt >= VS_LO && y_nxt < VS_HI);
      video_on    <= (x_nxt < HD) && (y_nxt < VD);
      frame_start <= wrap_all;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: two reduced-raster instances (divide-by-3 and
// divide-by-1) checked against an arithmetic raster model.
module tb_vga_sync_gen;

  localparam int HD = 20, HF = 4, HS = 4, HB = 6;
  localparam int VD = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int DA = 3;
  localparam int DB = 1;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pt;
    logic       von;
    logic       hs;
    logic       vs;
    logic       fs;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [9:0] xa, ya, xb, yb;
  logic pta, vona, hsa, vsa, fsa;
  logic ptb, vonb, hsb, vsb, fsb;

  int checks = 0;
  int errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(DA), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS),
    .H_BACK(HB), .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS),
    .V_BACK(VB)
  ) u_a (
    .clk(clk), .reset(reset), .x(xa), .y(ya), .p_tick(pta),
    .video_on(vona), .hsync(hsa), .vsync(vsa),
    .frame_start(fsa)
  );

  vga_sync_gen #(
    .CLK_DIV(DB), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS),
    .H_BACK(HB), .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS),
    .V_BACK(VB)
  ) u_b (
    .clk(clk), .reset(reset), .x(xb), .y(yb), .p_tick(ptb),
    .video_on(vonb), .hsync(hsb), .vsync(vsb),
    .frame_start(fsb)
  );

  // k = clock edges since reset release; k == 0 means reset state.
  function automatic obs_t model(int d, int k, bit rn);
    obs_t o;
    int pix, xi, yi;
    pix   = k / d;
    xi    = pix % HT;
    yi    = (pix / HT) % VT;
    o.x   = 10'(xi);
    o.y   = 10'(yi);
    o.pt  = ((k % d) == d - 1) && !rn;
    if (k == 0) begin
      o.von = 1'b0;
      o.hs  = 1'b1;
      o.vs  = 1'b1;
      o.fs  = 1'b0;
    end else begin
      o.von = (xi < HD) && (yi < VD);
      o.hs  = !(xi >= HD + HF && xi < HD + HF + HS);
      o.vs  = !(yi >= VD + VF && yi < VD + VF + VS);
      o.fs  = (k % (d * HT * VT)) == 0;
    end
    return o;
  endfunction

  task automatic cmp(string nm, obs_t act, obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got x=%0d y=%0d pt=%b von=%b hs=%b vs=%b fs=%b want x=%0d y=%0d pt=%b von=%b hs=%b vs=%b fs=%b",
        nm, $time, act.x, act.y, act.pt, act.von, act.hs, act.vs,
        act.fs, exp.x, exp.y, exp.pt, exp.von, exp.hs, exp.vs,
        exp.fs);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        cmp("div3", {xa, ya, pta, vona, hsa, vsa, fsa}, e.a);
        cmp("div1", {xb, yb, ptb, vonb, hsb, vsb, fsb}, e.b);
      end
    end
  end

  initial begin : driver
    int   k = 0;
    int   rst_left = 2;
    bit   hit = 0;
    bit   rn;
    obs_t cur;
    exp_t e;
    for (int c = 0; c < 7000; c++) begin
      @(posedge clk);
      if (reset) k = 0;
      else k++;
      cur = model(DA, k, 1'b0);
      rn = 1'b0;
      if (rst_left > 0) begin
        rn = 1'b1;
        rst_left--;
      end else if (!hit && c > 1500 && cur.x == 10'(HD + HF + 1)
                   && cur.y == 10'(VD + VF + 1)) begin
        rn  = 1'b1;
        hit = 1;
      end else if (c > 2600 && $urandom_range(0, 499) == 0) begin
        rn = 1'b1;
        rst_left = $urandom_range(0, 2);
      end
      #1;
      reset = rn;
      e.a = model(DA, k, rn);
      e.b = model(DB, k, rn);
      sbq.push_back(e);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0 || !hit) begin
      errors++;
      $display("FAIL drain got q=%0d hit=%0d want q=0 hit=1",
        sbq.size(), hit);
    end
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
